// File: rtl/vga_sync_decoder_pkg.sv
// Shared VGA 800x600@60 timing constants, field widths and sync-decoder state type.
// Used as parameter defaults by the sync decoder and the timing generator.
package vga_sync_decoder_pkg;

  localparam int unsigned VGA_H_TOTAL       = 1056;
  localparam int unsigned VGA_V_TOTAL       = 628;
  localparam int unsigned VGA_H_ACTIVE      = 800;
  localparam int unsigned VGA_V_ACTIVE      = 600;
  localparam int unsigned VGA_H_SYNC_START  = 840;
  localparam int unsigned VGA_V_SYNC_START  = 601;
  localparam int unsigned VGA_LOCK_FRAMES   = 2;

  localparam int unsigned CNT_W  = 11;
  localparam int unsigned RGB_W  = 12;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned GOOD_W = 4;

  localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } sync_state_t;

endpackage

// File: rtl/vga_crc16.sv
// One CRC-16-CCITT step over a 12-bit rgb word, MSB first, fully combinational.
module vga_crc16
  import vga_sync_decoder_pkg::*;
(
  input  logic [CRC_W-1:0] crc_in,
  input  logic [RGB_W-1:0] data,
  output logic [CRC_W-1:0] crc_c
);

  logic fb;

  always_comb begin
    crc_c = crc_in;
    fb    = 1'b0;
    for (int i = RGB_W - 1; i >= 0; i--) begin
      fb    = crc_c[CRC_W-1] ^ data[i];
      crc_c = {crc_c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA receive-side decoder: rebuilds pixel coordinates from hs/vs edges, checks timing, reports lock.
// Define VGA_FRAME_CRC_EN to add a per-frame CRC-16 of active pixels on frame_crc.
module vga_sync_decoder
  import vga_sync_decoder_pkg::*;
#(
  parameter int unsigned H_TOTAL      = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL,
  parameter int unsigned H_ACTIVE     = VGA_H_ACTIVE,
  parameter int unsigned V_ACTIVE     = VGA_V_ACTIVE,
  parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
  parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
  parameter int unsigned LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [CNT_W-1:0] hcount_out,
  output logic [CNT_W-1:0] vcount_out,
  output logic             de_out,
  output logic [RGB_W-1:0] rgb_out,
  output logic             frame_start,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CRC_W-1:0] frame_crc
);

  sync_state_t       state, state_nx;
  logic [CNT_W-1:0]  hcnt, hcnt_nx, vcnt, vcnt_nx;
  logic [GOOD_W-1:0] good, good_nx;
  logic [ERR_W-1:0]  err_nx;
  logic              hs_d, vs_d;
  logic              hs_rise, vs_rise, at_hs, at_vs, hs_miss, vs_miss, fail;
  logic              locked_nx, de_nx, fs_nx;

  // Counters hold the position of the pixel presented in the previous clock, so an edge
  // arriving on time sees the count one short of the sync start.
  always_comb begin
    state_nx = state;
    good_nx  = good;
    err_nx   = err_cnt;

    hs_rise = hs_in & ~hs_d;
    vs_rise = vs_in & ~vs_d;
    at_hs   = (hcnt == CNT_W'(H_SYNC_START - 1));
    at_vs   = at_hs & (vcnt == CNT_W'(V_SYNC_START));
    hs_miss = (hcnt == CNT_W'(H_SYNC_START)) & ~hs_d & ~hs_in;
    vs_miss = (hcnt == CNT_W'(H_SYNC_START)) & (vcnt == CNT_W'(V_SYNC_START)) & ~vs_d & ~vs_in;
    fail    = (hs_rise & ~at_hs) | (vs_rise & ~at_vs) | hs_miss | vs_miss;

    if (hcnt == CNT_W'(H_TOTAL - 1)) begin
      hcnt_nx = '0;
      vcnt_nx = (vcnt == CNT_W'(V_TOTAL - 1)) ? '0 : vcnt + CNT_W'(1);
    end else begin
      hcnt_nx = hcnt + CNT_W'(1);
      vcnt_nx = vcnt;
    end

    case (state)
      ST_SEARCH: begin
        if (vs_rise) begin
          hcnt_nx  = CNT_W'(H_SYNC_START);
          vcnt_nx  = CNT_W'(V_SYNC_START);
          good_nx  = '0;
          state_nx = ST_TRACK;
        end
      end
      ST_TRACK, ST_LOCKED: begin
        if (fail) begin
          err_nx   = (err_cnt == '1) ? err_cnt : err_cnt + ERR_W'(1);
          good_nx  = '0;
          state_nx = ST_SEARCH;
          if (vs_rise) begin
            hcnt_nx = CNT_W'(H_SYNC_START);
            vcnt_nx = CNT_W'(V_SYNC_START);
          end else if (hs_rise) begin
            hcnt_nx = CNT_W'(H_SYNC_START);
          end
        end else if (vs_rise && state == ST_TRACK) begin
          if (good == GOOD_W'(LOCK_FRAMES - 1)) state_nx = ST_LOCKED;
          else                                  good_nx  = good + GOOD_W'(1);
        end
      end
      default: state_nx = ST_SEARCH;
    endcase

    locked_nx = (state_nx == ST_LOCKED);
    de_nx     = locked_nx & (hcnt_nx < CNT_W'(H_ACTIVE)) & (vcnt_nx < CNT_W'(V_ACTIVE));
    fs_nx     = locked_nx & (hcnt_nx == '0) & (vcnt_nx == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_SEARCH;
      hcnt        <= '0;
      vcnt        <= '0;
      good        <= '0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      err_cnt     <= '0;
      locked      <= 1'b0;
      de_out      <= 1'b0;
      frame_start <= 1'b0;
      rgb_out     <= '0;
    end else begin
      state       <= state_nx;
      hcnt        <= hcnt_nx;
      vcnt        <= vcnt_nx;
      good        <= good_nx;
      hs_d        <= hs_in;
      vs_d        <= vs_in;
      err_cnt     <= err_nx;
      locked      <= locked_nx;
      de_out      <= de_nx;
      frame_start <= fs_nx;
      rgb_out     <= rgb_in;
    end
  end

  assign hcount_out = hcnt;
  assign vcount_out = vcnt;

`ifdef VGA_FRAME_CRC_EN
  logic [CRC_W-1:0] crc_acc, crc_seed, crc_step, crc_q;

  // The (0,0) pixel opens the new frame, so it is folded into a fresh seed.
  assign crc_seed = fs_nx ? CRC_INIT : crc_acc;

  vga_crc16 u_crc16 (
    .crc_in (crc_seed),
    .data   (rgb_in),
    .crc_c  (crc_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_acc <= CRC_INIT;
      crc_q   <= '0;
    end else begin
      if (!locked_nx)  crc_acc <= CRC_INIT;
      else if (de_nx)  crc_acc <= crc_step;
      if (fs_nx)       crc_q   <= crc_acc;
    end
  end

  assign frame_crc = crc_q;
`else
  assign frame_crc = '0;
`endif

endmodule
